// File: rtl/signed_div_pkg.sv
// Shared definitions for the signed divider: FSM state encoding, default sizes,
// the MIN-pattern helper and a carry-free two's complement negation.
package signed_div_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // Most negative two's complement value of a w-bit word, right-aligned.
  function automatic logic [63:0] min_pattern(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Copy bits up to and including the lowest 1, invert everything above it.
  // Needs no carry chain, so it does not compete with the add/sub slice.
  function automatic logic [63:0] negate(input logic [63:0] v);
    logic [63:0] r;
    logic        seen;
    r    = '0;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      r[i] = v[i] ^ seen;
      seen = seen | v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/signed_div_addsub.sv
// Ripple-carry add/subtract slice; the divider's single arithmetic resource.
// sub=1 computes a - b (a + ~b + 1), sub=0 computes a + b.
module div_addsub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout
);

  always_comb begin
    logic carry;
    logic bx;
    // NOTE: outputs get a default first so no path through this block can infer
    // a latch; blocking '=' is correct here because carry is a running value
    // within one evaluation, whereas clocked state always uses '<='.
    s     = '0;
    carry = sub;
    bx    = 1'b0;
    for (int i = 0; i < N; i++) begin
      bx    = b[i] ^ sub;
      s[i]  = a[i] ^ bx ^ carry;
      carry = (a[i] & bx) | (carry & (a[i] ^ bx));
    end
    cout = carry;
  end

endmodule

// File: rtl/signed_div_seq.sv
// Sequential signed divider: WIDTH restoring iterations on magnitudes, then sign fix.
// Optional macro SIGNED_DIV_DBZ_EN enables the divide-by-zero short path and dbz flag.
module signed_div_seq
  import signed_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             ovf,
  output logic             dbz
);

  localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(min_pattern(WIDTH));
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_a;
  logic             sign_b;
  logic             ovf_pend;
  logic [WIDTH-1:0] a_reg;   // |dividend| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] b_reg;   // divisor kept signed; sign selects add vs subtract
  logic [WIDTH-1:0] p_reg;   // partial remainder, always < |divisor|

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   sl_a;
  logic [WIDTH:0]   sl_b;
  logic [WIDTH:0]   sl_s;
  logic             sl_sub;
  logic             cout_unused;
  logic             keep;
  logic [WIDTH-1:0] rem_neg;

`ifdef SIGNED_DIV_DBZ_EN
  logic dbz_pend;
  logic dbz_q;
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

  assign p_shift = {p_reg, a_reg[WIDTH-1]};
  assign keep    = ~sl_s[WIDTH];
  assign rem_neg = WIDTH'(negate(64'(p_reg)));

  // The slice negates the dividend in IDLE, runs trial subtraction in ITER and
  // negates the quotient in FIX. A negative divisor is added rather than
  // subtracted, which yields P - |B| without ever forming |B| (works for MIN too).
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_sub = 1'b1;
    case (state)
      IDLE: begin
        sl_b = {dividend[WIDTH-1], dividend};
      end
      ITER: begin
        sl_a   = p_shift;
        sl_b   = {b_reg[WIDTH-1], b_reg};
        sl_sub = ~sign_b;
      end
      default: begin
        sl_b = {1'b0, a_reg};
      end
    endcase
  end

  div_addsub #(.N(WIDTH + 1)) u_addsub (
    .a    (sl_a),
    .b    (sl_b),
    .sub  (sl_sub),
    .s    (sl_s),
    .cout (cout_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with control; they are few and
      // this keeps every output and internal value defined straight out of reset.
      state    <= IDLE;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      ovf_pend <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      p_reg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      ovf      <= 1'b0;
`ifdef SIGNED_DIV_DBZ_EN
      dbz_pend <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_a   <= dividend[WIDTH-1];
            sign_b   <= divisor[WIDTH-1];
            a_reg    <= dividend[WIDTH-1] ? sl_s[WIDTH-1:0] : dividend;
            b_reg    <= divisor;
            p_reg    <= '0;
            cnt      <= '0;
            ovf_pend <= (dividend == MIN_VAL) && (divisor == '1);
            busy     <= 1'b1;
            state    <= ITER;
`ifdef SIGNED_DIV_DBZ_EN
            dbz_pend <= (divisor == '0);
            if (divisor == '0) begin
              a_reg <= '1;
              p_reg <= dividend;
              state <= FIX;
            end
`endif
          end
        end

        ITER: begin
          a_reg <= {a_reg[WIDTH-2:0], keep};
          p_reg <= keep ? sl_s[WIDTH-1:0] : p_shift[WIDTH-1:0];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end
        end

        FIX: begin
          quo   <= (sign_a ^ sign_b) ? sl_s[WIDTH-1:0] : a_reg;
          rem   <= sign_a ? rem_neg : p_reg;
          ovf   <= ovf_pend;
`ifdef SIGNED_DIV_DBZ_EN
          dbz_q <= dbz_pend;
          if (dbz_pend) begin
            quo <= a_reg;
            rem <= p_reg;
            ovf <= 1'b0;
          end
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Self-checking bench for signed_div_seq: scoreboard of expected results pushed
// at issue and compared when done pulses; covers reset, signs, overflow, zero divisor.
module tb_signed_div_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         ovf;
  logic         dbz;

  always #5 clk = ~clk;

  signed_div_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;
    int           lat;
    int           drive_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_done = 0;
  int           n_expected = 0;
  logic [W-1:0] last_quo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder follows dividend).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int drv);
    exp_t e;
    int   ia;
    int   ib;
    ia          = int'($signed(a));
    ib          = int'($signed(b));
    e.ovf       = 1'b0;
    e.dbz       = 1'b0;
    e.lat       = W + 2;
    e.drive_cyc = drv;
    if (ib == 0) begin
`ifdef SIGNED_DIV_DBZ_EN
      e.quo = '1;
      e.rem = a;
      e.dbz = 1'b1;
      e.lat = 2;
`else
      e.quo = (ia < 0) ? W'(1) : '1;
      e.rem = a;
`endif
    end else if (a == 16'h8000 && ib == -1) begin
      e.quo = a;
      e.rem = '0;
      e.ovf = 1'b1;
    end else begin
      e.quo = W'(ia / ib);
      e.rem = W'(ia % ib);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("quo", quo, e.quo);
        check("rem", rem, e.rem);
        check("ovf", ovf, e.ovf);
        check("dbz", dbz, e.dbz);
        check("latency", cyc - e.drive_cyc, e.lat);
        last_quo = e.quo;
      end
    end
  end

  // Drives start for one cycle from idle, then scrambles the operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b, cyc));
    n_expected++;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * W && sb.size() > 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("quo_hold", quo, last_quo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  int da[11] = '{100, -100, 100, -100, -32768, -32768, 123, -5, 32767, -32768, 7};
  int dv[11] = '{7, 7, -7, -7, -1, 1, 0, 0, -32768, -32768, 100};

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue(W'(da[i]), W'(dv[i]));
      drain();
    end

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = 16'h8000;
      if (i % 7 == 0) rb = W'($urandom_range(1, 5));
      issue(ra, rb);
      drain();
    end

    // start pulsed mid-operation must be ignored
    issue(W'(1000), W'(9));
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = W'(-4321);
    divisor  = W'(3);
    @(negedge clk);
    start    = 1'b0;
    drain();

    // start coincident with done is accepted
    issue(W'(-1234), W'(11));
    for (int i = 0; i < 4 * W && !done; i++) @(negedge clk);
    check("b2b_done_seen", done, 1);
    dividend = W'(5000);
    divisor  = W'(-3);
    start    = 1'b1;
    sb.push_back(model(dividend, divisor, cyc));
    n_expected++;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    drain();

    // reset in the middle of the iterations aborts without a done
    issue(W'(30000), W'(7));
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quo", quo, 0);
    check("midrst_rem", rem, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_dbz", dbz, 0);
    sb.delete();
    n_expected--;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(W'(-777), W'(13));
    drain();

    check("done_count", n_done, n_expected);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
